pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards that the EX-stage forwarding paths cannot cover and inserts one bubble for each.
- Freezes the whole pipeline while a data-memory access is outstanding and issues IF/ID flushes on taken branches resolved in ID.
- Keeps saturating stall and flush counters for performance reporting.

Parameters:
- CNT_W, 32, width of StallCount_o and FlushCount_o.
- MEM_TIMEOUT, 64, maximum number of cycles in MEM_WAIT before entering ERROR.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  level; pipeline runs only while it is high.
- IDRS1_i  in  5  rs1 of the instruction in ID.
- IDRS2_i  in  5  rs2 of the instruction in ID.
- EXRD_i  in  5  rd of the instruction in EX.
- EXMemRead_i  in  1  instruction in EX is a load.
- BranchTaken_i  in  1  branch in ID resolved taken.
- DMemReq_i  in  1  MEM stage is issuing a load or store this cycle.
- DMemAck_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC register update enable.
- IFIDWrite_o  out  1  IF/ID register update enable.
- IDEXBubble_o  out  1  load a NOP into ID/EX.
- IFIDFlush_o  out  1  clear IF/ID to a NOP.
- StallAll_o  out  1  hold every pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Error_o  out  1  sticky memory-timeout flag.
- StallCount_o  out  CNT_W  number of stall cycles.
- FlushCount_o  out  CNT_W  number of flush events.

Behaviour:
- States: IDLE, RUN, MEM_WAIT, ERROR. Reset drives the FSM to IDLE.
- Reset values: Error_o=0, counters=0, timeout counter=0. In IDLE: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=0, IFIDFlush_o=0, StallAll_o=1.
- IDLE -> RUN when start_i=1. From RUN or MEM_WAIT, start_i=0 returns the FSM to IDLE on the next edge; an outstanding access is abandoned and the timeout counter is cleared.
- Outputs are combinational from state and inputs (Mealy). Event priority in RUN:
  1. Memory stall: DMemReq_i=1 and DMemAck_i=0. StallAll_o=1, PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=0, IFIDFlush_o=0. Next state is MEM_WAIT. A same-cycle DMemReq_i=1 with DMemAck_i=1 is a zero-wait access: no stall, remain in RUN.
  2. Load-use: EXMemRead_i=1, EXRD_i!=0, and (EXRD_i==IDRS1_i or EXRD_i==IDRS2_i). PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, IFIDFlush_o=0 even if BranchTaken_i=1. The branch re-resolves next cycle with forwarded data.
  3. BranchTaken_i=1: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1.
  4. Otherwise: PCWrite_o=1, IFIDWrite_o=1, all other outputs 0.
- MEM_WAIT:
  - While DMemAck_i=0: StallAll_o=1, other control outputs as in RUN priority 1; hazard and branch inputs are ignored.
  - On DMemAck_i=1: StallAll_o=0, outputs follow RUN priorities 2-4 for that cycle, next state RUN, timeout counter cleared.
- Timeout: the counter increments every MEM_WAIT cycle with DMemAck_i=0. When it reaches MEM_TIMEOUT-1 and ack is still low, next state is ERROR.
- ERROR: Error_o=1, StallAll_o=1, all enables 0. Exits only via rst_i; start_i is ignored.
- StallCount_o increments by 1 in every RUN or MEM_WAIT cycle where StallAll_o=1 or IDEXBubble_o=1. FlushCount_o increments by 1 per cycle with IFIDFlush_o=1. Both saturate at all-ones, do not count in IDLE or ERROR, and retain their value across IDLE.
- Asserting rst_i mid-MEM_WAIT immediately clears state, counters and Error_o, with no cycle delay.

Test Plan:
- Reset, then start_i=1 with no hazards for 10 cycles -> PCWrite_o=1 and IFIDWrite_o=1 every cycle, StallCount_o=0, FlushCount_o=0.
- EXMemRead_i=1, EXRD_i=5, IDRS2_i=5 for one cycle -> IDEXBubble_o=1, PCWrite_o=0 that cycle, StallCount_o=1. Repeat with EXRD_i=0 -> no bubble.
- Load-use with BranchTaken_i=1 in the same cycle -> bubble only, IFIDFlush_o=0. Next cycle BranchTaken_i=1 with no hazard -> IFIDFlush_o=1, FlushCount_o=1.
- DMemReq_i=1 at cycle t, DMemAck_i=1 at t+3 -> StallAll_o=1 for cycles t..t+2, 0 at t+3, back in RUN, StallCount_o=3.
- DMemReq_i=1 and DMemAck_i never asserted, MEM_TIMEOUT=4 -> ERROR after 4 wait cycles, Error_o=1 sticky. Assert rst_i low -> Error_o=0 immediately.
- Force StallCount_o near all-ones with CNT_W=4 (15 stall cycles, then 3 more) -> counter holds at 15 with no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RISC-V pipeline.
// Inserts load-use bubbles and freezes the pipeline during data-memory waits.
// Flushes IF/ID on taken branches and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IDRS1_i,
  input  logic [4:0]       IDRS2_i,
  input  logic [4:0]       EXRD_i,
  input  logic             EXMemRead_i,
  input  logic             BranchTaken_i,
  input  logic             DMemReq_i,
  input  logic             DMemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEXBubble_o,
  output logic             IFIDFlush_o,
  output logic             StallAll_o,
  output logic             Error_o,
  output logic [CNT_W-1:0] StallCount_o,
  output logic [CNT_W-1:0] FlushCount_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_ERROR    = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            load_use;
  logic            active;
  logic            stall_inc;

  // Counters stop at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // x0 is never a real producer, so a load targeting it cannot cause a hazard.
  assign load_use = EXMemRead_i && (EXRD_i != 5'd0) &&
                    ((EXRD_i == IDRS1_i) || (EXRD_i == IDRS2_i));

  assign active    = (state == S_RUN) || (state == S_MEM_WAIT);
  assign stall_inc = active && (StallAll_o || IDEXBubble_o);
  assign Error_o   = (state == S_ERROR);

  // Mealy outputs and next-state; defaults describe a fully frozen pipeline.
  always_comb begin
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    IFIDFlush_o  = 1'b0;
    StallAll_o   = 1'b1;
    state_nxt    = state;
    to_cnt_nxt   = to_cnt;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (state == S_RUN && DMemReq_i && !DMemAck_i) begin
          state_nxt  = S_MEM_WAIT;
          to_cnt_nxt = '0;
        end else if (state == S_MEM_WAIT && !DMemAck_i) begin
          if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) state_nxt = S_ERROR;
          else                                  to_cnt_nxt = to_cnt + TO_W'(1);
        end else begin
          // No memory stall this cycle: resolve load-use, then branch.
          StallAll_o   = 1'b0;
          state_nxt    = S_RUN;
          to_cnt_nxt   = '0;
          PCWrite_o    = !load_use;
          IFIDWrite_o  = !load_use;
          IDEXBubble_o = load_use;
          IFIDFlush_o  = !load_use && BranchTaken_i;
        end
        // Dropping start abandons any outstanding access.
        if (!start_i) begin
          state_nxt  = S_IDLE;
          to_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_ERROR;
      end
    endcase
  end

  // FSM and timeout counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  // Performance counters; they hold their value while idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      StallCount_o <= '0;
      FlushCount_o <= '0;
    end else begin
      if (stall_inc)   StallCount_o <= sat_inc(StallCount_o);
      if (IFIDFlush_o) FlushCount_o <= sat_inc(FlushCount_o);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with small counters and timeout.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, exrd = '0;
  logic       exmr = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
  logic       pcw, ifidw, bub, flush, stall, err;
  logic [3:0] scnt, fcnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic [5:0] o;   // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallAll, Error}
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;
  exp_t sb[$];

  localparam logic [5:0] O_IDLE = 6'b000010;
  localparam logic [5:0] O_RUN  = 6'b110000;
  localparam logic [5:0] O_BUB  = 6'b001000;
  localparam logic [5:0] O_FLS  = 6'b110100;
  localparam logic [5:0] O_MEM  = 6'b000010;
  localparam logic [5:0] O_ERR  = 6'b000011;

  pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .TO_W(3)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .IDRS1_i(rs1), .IDRS2_i(rs2), .EXRD_i(exrd),
    .EXMemRead_i(exmr), .BranchTaken_i(br),
    .DMemReq_i(req), .DMemAck_i(ack),
    .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .IDEXBubble_o(bub),
    .IFIDFlush_o(flush), .StallAll_o(stall), .Error_o(err),
    .StallCount_o(scnt), .FlushCount_o(fcnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge and queue what must be seen.
  task automatic step(input string nm, input logic rn, input logic st,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic mr, input logic b, input logic rq, input logic ak,
                      input logic [5:0] eo, input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    @(negedge clk);
    rst_n = rn; start = st; rs1 = r1; rs2 = r2; exrd = rd;
    exmr = mr; br = b; req = rq; ack = ak;
    e.nm = nm; e.o = eo; e.sc = esc; e.fc = efc;
    sb.push_back(e);
  endtask

  // Monitor: outputs are settled 1 time unit after the falling edge.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = {pcw, ifidw, bub, flush, stall, err};
        total++;
        if (act !== e.o) begin
          bad++;
          $display("FAIL %s outs: got %b want %b", e.nm, act, e.o);
        end
        total++;
        if (scnt !== e.sc) begin
          bad++;
          $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, scnt, e.sc);
        end
        total++;
        if (fcnt !== e.fc) begin
          bad++;
          $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, fcnt, e.fc);
        end
      end
    end
  end

  initial begin
    int guard;
    //    name          rn st rs1 rs2 rd mr br rq ak  outs    sc fc
    step("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0);
    step("idle_start",  1, 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0);
    for (int i = 0; i < 10; i++)
      step("run_clean", 1, 1, 1, 2, 3, 0, 0, 0, 0, O_RUN,  0, 0);
    step("lu_rs2",      1, 1, 0, 5, 5, 1, 0, 0, 0, O_BUB,  0, 0);
    step("lu_x0",       1, 1, 0, 0, 0, 1, 0, 0, 0, O_RUN,  1, 0);
    step("lu_br",       1, 1, 7, 1, 7, 1, 1, 0, 0, O_BUB,  1, 0);
    step("br_taken",    1, 1, 7, 1, 9, 0, 1, 0, 0, O_FLS,  2, 0);
    step("after_br",    1, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  2, 1);
    step("mem_t0",      1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  2, 1);
    step("mem_t1",      1, 1, 3, 0, 3, 1, 1, 1, 0, O_MEM,  3, 1);
    step("mem_t2",      1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  4, 1);
    step("mem_t3_ack",  1, 1, 0, 0, 0, 0, 0, 1, 1, O_RUN,  5, 1);
    step("zero_wait",   1, 1, 0, 0, 0, 0, 0, 1, 1, O_RUN,  5, 1);
    step("after_zw",    1, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  5, 1);
    step("to_req",      1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  5, 1);
    step("to_w1",       1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  6, 1);
    step("to_w2",       1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  7, 1);
    step("to_w3",       1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  8, 1);
    step("to_w4",       1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  9, 1);
    step("err_a",       1, 1, 0, 0, 0, 0, 0, 1, 1, O_ERR, 10, 1);
    step("err_nostart", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_ERR, 10, 1);
    step("err_sticky",  1, 1, 0, 0, 0, 0, 0, 0, 0, O_ERR, 10, 1);
    step("rst_in_err",  0, 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0);
    step("restart",     1, 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0);
    step("mw2_req",     1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  0, 0);
    step("mw2_wait",    1, 1, 0, 0, 0, 0, 0, 1, 0, O_MEM,  1, 0);
    step("rst_in_mw",   0, 1, 0, 0, 0, 0, 0, 1, 0, O_IDLE, 0, 0);
    step("restart2",    1, 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0);
    for (int i = 0; i < 15; i++)
      step("sat_fill",  1, 1, 4, 0, 4, 1, 0, 0, 0, O_BUB, 4'(i), 0);
    for (int i = 0; i < 3; i++)
      step("sat_hold",  1, 1, 4, 0, 4, 1, 0, 0, 0, O_BUB, 15, 0);
    step("run_stop",    1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  15, 0);
    step("idle_retain", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 15, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
